// File: rtl/rx_eth_dispatch.sv
// rx_eth_dispatch: store-and-forward Ethernet RX buffer, IPv4/ARP dispatcher.
// Define RX_DISPATCH_PROMISC_EN to accept any dst_mac (eth_type check only).
module rx_eth_dispatch #(
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned DESC_W    = 2,
   parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_01_02
) (
   input  logic        s_axis_aclk,
   input  logic        s_axis_aresetn,
   input  logic [47:0] dst_mac,
   input  logic [15:0] eth_type,
   input  logic        fcs_err,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tuser,
   input  logic        s_axis_tlast,
   output logic [7:0]  m0_axis_tdata,
   output logic        m0_axis_tvalid,
   input  logic        m0_axis_tready,
   output logic        m0_axis_tuser,
   output logic        m0_axis_tlast,
   output logic [7:0]  m1_axis_tdata,
   output logic        m1_axis_tvalid,
   input  logic        m1_axis_tready,
   output logic        m1_axis_tuser,
   output logic        m1_axis_tlast,
   output logic [15:0] filt_drop_cnt,
   output logic [15:0] fcs_drop_cnt,
   output logic [15:0] ovf_drop_cnt
);
   localparam int unsigned PW = ADDR_W + 1;
   localparam int unsigned DW = DESC_W + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [DW-1:0] DDEPTH = {1'b1, {DESC_W{1'b0}}};
   localparam logic [PW-1:0] P_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [DW-1:0] D_ONE = {{DESC_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wst_t;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} rdst_t;

   logic [7:0]    mem [0:(1<<ADDR_W)-1];
   logic [11:0]   desc_mem [0:(1<<DESC_W)-1];

   wst_t          wst_q, wst_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_q, commit_d;
   logic [10:0]   len_q, len_d, plen;
   logic          ovf_q, ovf_d, wdest_q, wdest_d;
   logic          we, push, inc_filt, inc_fcs, inc_ovf;
   logic [15:0]   filt_q, fcs_q, ovfc_q;
   logic [DW-1:0] dwr_q, drd_q;

   rdst_t         rs_q, rs_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, raddr;
   logic [10:0]   cnt_q, cnt_d, rlen_q, rlen_d;
   logic          rdest_q, rdest_d, pop;
   logic [7:0]    ram_q;
   logic [11:0]   desc_rd;

   logic full, dfull, dempty, mac_ok, type_ok;
   logic ovalid, hs, first, last;

   assign full   = (wr_ptr_q - rd_ptr_q) == DEPTH;
   assign dfull  = (dwr_q - drd_q) == DDEPTH;
   assign dempty = dwr_q == drd_q;
   assign plen   = len_q - 11'd3;
   assign desc_rd = desc_mem[drd_q[DESC_W-1:0]];

`ifdef RX_DISPATCH_PROMISC_EN
   logic unused_mac;
   assign unused_mac = ^dst_mac;
   assign mac_ok = 1'b1;
`else
   assign mac_ok = (dst_mac == LOCAL_MAC) || (dst_mac == 48'hFFFF_FFFF_FFFF);
`endif
   assign type_ok = (eth_type == 16'h0800) || (eth_type == 16'h0806);

   // Write side: filter, buffer, and commit or roll back at end of frame
   always_comb begin
      wst_d    = wst_q;
      wr_ptr_d = wr_ptr_q;
      commit_d = commit_q;
      len_d    = len_q;
      ovf_d    = ovf_q;
      wdest_d  = wdest_q;
      we       = 1'b0;
      push     = 1'b0;
      inc_filt = 1'b0;
      inc_fcs  = 1'b0;
      inc_ovf  = 1'b0;
      unique case (wst_q)
         W_IDLE: if (s_axis_tvalid && s_axis_tuser) begin
            if (s_axis_tlast) begin
               inc_filt = 1'b1;
            end else if (mac_ok && type_ok) begin
               we      = !full;
               ovf_d   = full;
               len_d   = 11'd1;
               wdest_d = (eth_type == 16'h0806);
               wst_d   = W_RECV;
               if (!full) wr_ptr_d = wr_ptr_q + P_ONE;
            end else begin
               wst_d = W_DROP;
            end
         end
         W_RECV: if (s_axis_tvalid) begin
            we    = !full && !ovf_q;
            ovf_d = ovf_q || full;
            len_d = len_q + 11'd1;
            if (we) wr_ptr_d = wr_ptr_q + P_ONE;
            if (s_axis_tlast) begin
               wst_d = W_IDLE;
               if (fcs_err) inc_fcs = 1'b1;
               else if (ovf_q || full || dfull) inc_ovf = 1'b1;
               else if (len_q <= 11'd3) inc_filt = 1'b1;
               else begin
                  push     = 1'b1;
                  commit_d = commit_q + PW'(plen);
               end
               wr_ptr_d = commit_d;
            end
         end
         W_DROP: if (s_axis_tvalid && s_axis_tlast) begin
            inc_filt = 1'b1;
            wst_d    = W_IDLE;
         end
         default: wst_d = W_IDLE;
      endcase
   end

   // Write side state, descriptor pointers and saturating drop counters
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         wst_q    <= W_IDLE;
         wr_ptr_q <= '0;
         commit_q <= '0;
         len_q    <= '0;
         ovf_q    <= 1'b0;
         wdest_q  <= 1'b0;
         dwr_q    <= '0;
         drd_q    <= '0;
         filt_q   <= '0;
         fcs_q    <= '0;
         ovfc_q   <= '0;
      end else begin
         wst_q    <= wst_d;
         wr_ptr_q <= wr_ptr_d;
         commit_q <= commit_d;
         len_q    <= len_d;
         ovf_q    <= ovf_d;
         wdest_q  <= wdest_d;
         if (push) dwr_q <= dwr_q + D_ONE;
         if (pop) drd_q <= drd_q + D_ONE;
         if (inc_filt && filt_q != 16'hFFFF) filt_q <= filt_q + 16'd1;
         if (inc_fcs && fcs_q != 16'hFFFF) fcs_q <= fcs_q + 16'd1;
         if (inc_ovf && ovfc_q != 16'hFFFF) ovfc_q <= ovfc_q + 16'd1;
      end
   end

   // Storage arrays carry no reset
   always_ff @(posedge s_axis_aclk) begin
      if (we) mem[wr_ptr_q[ADDR_W-1:0]] <= s_axis_tdata;
      if (push) desc_mem[dwr_q[DESC_W-1:0]] <= {wdest_q, plen};
   end

   // Read side: address stays on the presented byte until it is accepted
   always_comb begin
      rs_d     = rs_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      rlen_d   = rlen_q;
      rdest_d  = rdest_q;
      pop      = 1'b0;
      raddr    = rd_ptr_q;
      unique case (rs_q)
         R_IDLE: if (!dempty) begin
            pop     = 1'b1;
            rdest_d = desc_rd[11];
            rlen_d  = desc_rd[10:0];
            cnt_d   = 11'd1;
            rs_d    = R_LOAD;
         end
         R_LOAD: rs_d = R_DATA;
         R_DATA: if (hs) begin
            rd_ptr_d = rd_ptr_q + P_ONE;
            raddr    = rd_ptr_d;
            if (last) rs_d = R_IDLE;
            else cnt_d = cnt_q + 11'd1;
         end
         default: rs_d = R_IDLE;
      endcase
   end

   // Read side state and synchronous RAM output register
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         rs_q     <= R_IDLE;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rlen_q   <= '0;
         rdest_q  <= 1'b0;
         ram_q    <= 8'h00;
      end else begin
         rs_q     <= rs_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rlen_q   <= rlen_d;
         rdest_q  <= rdest_d;
         ram_q    <= mem[raddr[ADDR_W-1:0]];
      end
   end

   assign ovalid = (rs_q == R_DATA);
   assign first  = ovalid && (cnt_q == 11'd1);
   assign last   = ovalid && (cnt_q == rlen_q);
   assign hs     = ovalid && (rdest_q ? m1_axis_tready : m0_axis_tready);

   assign m0_axis_tdata  = ram_q;
   assign m0_axis_tvalid = ovalid && !rdest_q;
   assign m0_axis_tuser  = first && !rdest_q;
   assign m0_axis_tlast  = last && !rdest_q;
   assign m1_axis_tdata  = ram_q;
   assign m1_axis_tvalid = ovalid && rdest_q;
   assign m1_axis_tuser  = first && rdest_q;
   assign m1_axis_tlast  = last && rdest_q;

   assign filt_drop_cnt = filt_q;
   assign fcs_drop_cnt  = fcs_q;
   assign ovf_drop_cnt  = ovfc_q;
endmodule

// File: tb/tb_rx_eth_dispatch.sv
// tb_rx_eth_dispatch: directed bench for rx_eth_dispatch (ADDR_W=6).
// Honours RX_DISPATCH_PROMISC_EN for the foreign-MAC case.
module tb_rx_eth_dispatch;
   localparam logic [47:0] LMAC = 48'h00_0A_35_00_01_02;
   localparam logic [47:0] BMAC = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [47:0] dst_mac = '0;
   logic [15:0] eth_type = '0;
   logic        fcs_err = 1'b0;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tuser = 1'b0;
   logic        s_tlast = 1'b0;
   logic [7:0]  m0_tdata, m1_tdata;
   logic        m0_tvalid, m0_tuser, m0_tlast;
   logic        m1_tvalid, m1_tuser, m1_tlast;
   logic        m0_tready = 1'b1;
   logic        m1_tready = 1'b1;
   logic [15:0] filt_cnt, fcs_cnt, ovf_cnt;

   logic rdy0_cfg = 1'b1;
   logic rdy1_cfg = 1'b1;
   logic tog1 = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   logic [9:0] q0[$];
   logic [9:0] q1[$];
   logic hold0 = 1'b0, hold1 = 1'b0;
   logic [9:0] h0 = '0, h1 = '0;

   rx_eth_dispatch #(.ADDR_W(6), .DESC_W(2), .LOCAL_MAC(LMAC)) dut (
      .s_axis_aclk   (clk),
      .s_axis_aresetn(rstn),
      .dst_mac       (dst_mac),
      .eth_type      (eth_type),
      .fcs_err       (fcs_err),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tuser  (s_tuser),
      .s_axis_tlast  (s_tlast),
      .m0_axis_tdata (m0_tdata),
      .m0_axis_tvalid(m0_tvalid),
      .m0_axis_tready(m0_tready),
      .m0_axis_tuser (m0_tuser),
      .m0_axis_tlast (m0_tlast),
      .m1_axis_tdata (m1_tdata),
      .m1_axis_tvalid(m1_tvalid),
      .m1_axis_tready(m1_tready),
      .m1_axis_tuser (m1_tuser),
      .m1_axis_tlast (m1_tlast),
      .filt_drop_cnt (filt_cnt),
      .fcs_drop_cnt  (fcs_cnt),
      .ovf_drop_cnt  (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // tready drivers, updated just after each rising edge
   always @(posedge clk) begin
      #1;
      m0_tready = rdy0_cfg;
      m1_tready = tog1 ? ~m1_tready : rdy1_cfg;
   end

   // output capture plus hold-while-stalled check
   always @(negedge clk) begin
      if (hold0)
         chk("hold0", {m0_tvalid, m0_tuser, m0_tlast, m0_tdata}, {1'b1, h0});
      if (hold1)
         chk("hold1", {m1_tvalid, m1_tuser, m1_tlast, m1_tdata}, {1'b1, h1});
      hold0 = m0_tvalid && !m0_tready;
      hold1 = m1_tvalid && !m1_tready;
      h0 = {m0_tuser, m0_tlast, m0_tdata};
      h1 = {m1_tuser, m1_tlast, m1_tdata};
      if (m0_tvalid && m0_tready) q0.push_back({m0_tuser, m0_tlast, m0_tdata});
      if (m1_tvalid && m1_tready) q1.push_back({m1_tuser, m1_tlast, m1_tdata});
   end

   task automatic drive(input logic v, input logic u, input logic l,
                        input logic f, input logic [7:0] d);
      @(posedge clk);
      #1;
      s_tvalid = v;
      s_tuser  = u;
      s_tlast  = l;
      fcs_err  = f;
      s_tdata  = d;
   endtask

   // n payload bytes seed, seed+1, ... followed by 4 FCS bytes
   task automatic send(input logic [47:0] mac, input logic [15:0] et,
                       input int n, input logic fe, input logic [7:0] seed);
      logic [7:0] b;
      dst_mac  = mac;
      eth_type = et;
      for (int i = 0; i < n + 4; i++) begin
         b = (i < n) ? seed + 8'(i) : 8'hF0 + 8'(i - n);
         drive(1'b1, i == 0, i == n + 3, fe && (i == n + 3), b);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic expect_frame(input int port, input int n,
                               input logic [7:0] seed, input string tag);
      int t;
      int err;
      int sz;
      int osz;
      logic [9:0] e;
      logic [9:0] x;
      t = 0;
      err = 0;
      sz = (port == 0) ? q0.size() : q1.size();
      while (sz < n && t < 3000) begin
         @(negedge clk);
         t++;
         sz = (port == 0) ? q0.size() : q1.size();
      end
      repeat (8) @(negedge clk);
      sz  = (port == 0) ? q0.size() : q1.size();
      osz = (port == 0) ? q1.size() : q0.size();
      chk({tag, "_len"}, sz, n);
      chk({tag, "_other"}, osz, 0);
      for (int i = 0; i < n && i < sz; i++) begin
         if (port == 0) e = q0.pop_front();
         else e = q1.pop_front();
         x = {i == 0, i == n - 1, 8'(seed + 8'(i))};
         if (i == 0) chk({tag, "_first"}, e, x);
         if (e !== x) err++;
      end
      chk({tag, "_data"}, err, 0);
      q0.delete();
      q1.delete();
   endtask

   initial begin
      int lat;
      int nl;
      int exp_filt;
      lat = 0;
      nl = 0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("rst_v", {m0_tvalid, m1_tvalid}, 0);
      chk("rst_ul", {m0_tuser, m0_tlast, m1_tuser, m1_tlast}, 0);
      chk("rst_d", {m0_tdata, m1_tdata}, 0);
      chk("rst_cnt", {filt_cnt, fcs_cnt, ovf_cnt}, 0);

      // unicast IPv4, latency and content
      send(LMAC, 16'h0800, 46, 1'b0, 8'h01);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (m0_tvalid) begin
            lat = k;
            break;
         end
      end
      chk("t1_latency", lat, 3);
      expect_frame(0, 46, 8'h01, "t1");
      chk("t1_cnt", {filt_cnt, fcs_cnt, ovf_cnt}, 0);

      // broadcast ARP with toggling tready
      tog1 = 1'b1;
      send(BMAC, 16'h0806, 28, 1'b0, 8'h40);
      expect_frame(1, 28, 8'h40, "t2");
      tog1 = 1'b0;

      // FCS error then good frame: rollback
      send(LMAC, 16'h0800, 20, 1'b1, 8'h10);
      send(LMAC, 16'h0800, 30, 1'b0, 8'h80);
      expect_frame(0, 30, 8'h80, "t3");
      chk("t3_cnt", {filt_cnt, fcs_cnt, ovf_cnt}, {16'd0, 16'd1, 16'd0});

      // filter, runt and zero-payload drops
      send(48'h1122_3344_5566, 16'h0800, 10, 1'b0, 8'hA0);
`ifdef RX_DISPATCH_PROMISC_EN
      expect_frame(0, 10, 8'hA0, "t4_foreign");
      exp_filt = 3;
`else
      repeat (20) @(negedge clk);
      chk("t4_foreign_q", q0.size() + q1.size(), 0);
      exp_filt = 4;
`endif
      send(LMAC, 16'h86DD, 10, 1'b0, 8'hB0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      send(LMAC, 16'h0800, 0, 1'b0, 8'h00);
      repeat (20) @(negedge clk);
      chk("t4_q", q0.size() + q1.size(), 0);
      chk("t4_filt", filt_cnt, exp_filt);
      chk("t4_fcs_ovf", {fcs_cnt, ovf_cnt}, {16'd1, 16'd0});

      // overflow with m0 stalled
      rdy0_cfg = 1'b0;
      send(LMAC, 16'h0800, 40, 1'b0, 8'h20);
      send(LMAC, 16'h0800, 40, 1'b0, 8'h60);
      repeat (5) @(negedge clk);
      chk("t5_ovf", ovf_cnt, 1);
      chk("t5_stalled_q", q0.size(), 0);
      chk("t5_stalled_v", m0_tvalid, 1);
      rdy0_cfg = 1'b1;
      expect_frame(0, 40, 8'h20, "t5a");
      send(LMAC, 16'h0800, 40, 1'b0, 8'h90);
      expect_frame(0, 40, 8'h90, "t5c");
      chk("t5_cnt", {filt_cnt, fcs_cnt, ovf_cnt},
          {16'(exp_filt), 16'd1, 16'd1});

      // reset mid-frame on both sides
      send(LMAC, 16'h0800, 40, 1'b0, 8'h30);
      lat = 0;
      while (q0.size() < 5 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("t6_started", q0.size() >= 5, 1);
      for (int i = 0; i < 10; i++)
         drive(1'b1, i == 0, 1'b0, 1'b0, 8'hC0 + 8'(i));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hCA);
      rstn = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hCB);
      rstn = 1'b1;
      @(negedge clk);
      chk("t6_rst_v", {m0_tvalid, m1_tvalid}, 0);
      chk("t6_rst_d", {m0_tdata, m0_tuser, m0_tlast}, 0);
      chk("t6_rst_cnt", {filt_cnt, fcs_cnt, ovf_cnt}, 0);
      foreach (q0[i]) if (q0[i][8]) nl++;
      chk("t6_no_tlast", nl, 0);
      for (int i = 12; i < 20; i++)
         drive(1'b1, 1'b0, i == 19, 1'b0, 8'hC0 + 8'(i));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      q0.delete();
      q1.delete();
      repeat (20) @(negedge clk);
      chk("t6_idle_q", q0.size() + q1.size(), 0);
      chk("t6_pre_cnt", {filt_cnt, fcs_cnt, ovf_cnt}, 0);
      send(LMAC, 16'h0800, 12, 1'b0, 8'h70);
      expect_frame(0, 12, 8'h70, "t6");
      chk("t6_cnt", {filt_cnt, fcs_cnt, ovf_cnt}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
